// File: rtl/pifo_calendar_enq_ctrl.sv
// rtl/pifo_calendar_enq_ctrl.sv - calendar-queue enqueue/dequeue controller in front of a PIFO atom chain
//
// Purpose: stages enqueue requests {address, delta} in a small FIFO and turns
// each one into an absolute-rank PIFO element (rank = vtime + delta, with an
// overflow epoch bit). It issues insert/pop strobes to the atom chain, tracks
// occupancy, and advances virtual time to the rank of each popped head.
//
// Optional feature: define PIFO_ENQ_BYPASS_EN to let a request that arrives
// while the staging FIFO is empty go straight to the atoms in its accept cycle.
//
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   s_enq_valid/ready          enqueue handshake
//   s_enq_address, s_enq_delta buffer address and rank offset of the request
//   s_deq_req                  pop request (ignored when the chain is empty)
//   m_deq_valid/element        one-cycle pulse with the popped head element
//   in_pifo_head               head atom contents
//   out_pifo_input             element broadcast to the atoms (0 when idle)
//   out_ctl_insert/pop         atom control strobes
//   out_global_overflow_bit    overflow bit of the last dequeued element
//   out_pifo_count             number of occupied atoms

module pifo_calendar_enq_ctrl #(
   parameter int ELEMENT_WIDTH           = 32,
   parameter int ELEMENT_RANK_WIDTH      = 18,
   parameter int PIFO_INFO_ADDRESS_WIDTH = 12,
   parameter int PIFO_DEPTH              = 16,
   parameter int FIFO_DEPTH              = 4
) (
   input  logic                                 clk,
   input  logic                                 rstn,
   input  logic                                 s_enq_valid,
   output logic                                 s_enq_ready,
   input  logic [PIFO_INFO_ADDRESS_WIDTH-1:0]   s_enq_address,
   input  logic [ELEMENT_RANK_WIDTH-1:0]        s_enq_delta,
   input  logic                                 s_deq_req,
   output logic                                 m_deq_valid,
   output logic [ELEMENT_WIDTH-1:0]             m_deq_element,
   input  logic [ELEMENT_WIDTH-1:0]             in_pifo_head,
   output logic [ELEMENT_WIDTH-1:0]             out_pifo_input,
   output logic                                 out_ctl_insert,
   output logic                                 out_ctl_pop,
   output logic                                 out_global_overflow_bit,
   output logic [$clog2(PIFO_DEPTH+1)-1:0]      out_pifo_count
);

   localparam int RW    = ELEMENT_RANK_WIDTH;
   localparam int AW    = PIFO_INFO_ADDRESS_WIDTH;
   localparam int CNT_W = $clog2(PIFO_DEPTH + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int ENT_W = AW + RW;

   // Staging FIFO entries are {address, delta}; pointers carry one extra
   // wrap bit so full and empty are distinguishable.
   logic [ENT_W-1:0]   fifo_mem_q [FIFO_DEPTH];
   logic [ENT_W-1:0]   fifo_mem_d [FIFO_DEPTH];
   logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
   logic [RW-1:0]      vtime_q, vtime_d;
   logic               gov_q, gov_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               deq_valid_q, deq_valid_d;
   logic [ELEMENT_WIDTH-1:0] deq_elem_q, deq_elem_d;

   logic               fifo_empty, fifo_full;
   logic               enq_fire, fifo_push, fifo_pop;
   logic               pop_issue, ins_allowed, bypass, insert_issue;
   logic [ENT_W-1:0]   head_entry, ins_entry;
   logic [AW-1:0]      ins_addr;
   logic [RW-1:0]      ins_delta;
   logic [RW:0]        rank_sum;

   always_comb begin
      fifo_empty = (wr_ptr_q == rd_ptr_q);
      fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
      head_entry = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];

      enq_fire   = rstn & s_enq_valid & ~fifo_full;
      pop_issue  = rstn & s_deq_req & (count_q != '0);
      // A full chain can still take an insert when a pop frees a slot in the
      // same cycle.
      ins_allowed = (count_q < CNT_W'(PIFO_DEPTH)) | pop_issue;

`ifdef PIFO_ENQ_BYPASS_EN
      // Only an empty FIFO may be bypassed, which keeps request order intact.
      bypass = fifo_empty & enq_fire & ins_allowed;
`else
      bypass = 1'b0;
`endif

      fifo_pop     = rstn & ~fifo_empty & ins_allowed;
      fifo_push    = enq_fire & ~bypass;
      insert_issue = fifo_pop | bypass;

      ins_entry = fifo_empty ? {s_enq_address, s_enq_delta} : head_entry;
      ins_addr  = ins_entry[ENT_W-1:RW];
      ins_delta = ins_entry[RW-1:0];

      // The carry out of vtime + delta means the rank wrapped into the next
      // epoch, so it flips the element's overflow bit relative to the epoch
      // of the current head.
      rank_sum = {1'b0, vtime_q} + {1'b0, ins_delta};

      out_pifo_input = '0;
      if (insert_issue) begin
         out_pifo_input = {1'b1, gov_q ^ rank_sum[RW], rank_sum[RW-1:0], ins_addr};
      end

      fifo_mem_d = fifo_mem_q;
      if (fifo_push) begin
         fifo_mem_d[wr_ptr_q[PTR_W-1:0]] = {s_enq_address, s_enq_delta};
      end
      wr_ptr_d = fifo_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = fifo_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

      count_d = count_q;
      if (insert_issue && !pop_issue) begin
         count_d = count_q + 1'b1;
      end else if (pop_issue && !insert_issue) begin
         count_d = count_q - 1'b1;
      end

      // Virtual time follows the head being popped; inserts in the same
      // cycle have already used the old value above.
      vtime_d     = pop_issue ? in_pifo_head[AW +: RW] : vtime_q;
      gov_d       = pop_issue ? in_pifo_head[ELEMENT_WIDTH-2] : gov_q;
      deq_valid_d = pop_issue;
      deq_elem_d  = pop_issue ? in_pifo_head : deq_elem_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem_q[i] <= '0;
         end
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         vtime_q     <= '0;
         gov_q       <= 1'b0;
         count_q     <= '0;
         deq_valid_q <= 1'b0;
         deq_elem_q  <= '0;
      end else begin
         fifo_mem_q  <= fifo_mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         vtime_q     <= vtime_d;
         gov_q       <= gov_d;
         count_q     <= count_d;
         deq_valid_q <= deq_valid_d;
         deq_elem_q  <= deq_elem_d;
      end
   end

   assign s_enq_ready             = rstn & ~fifo_full;
   assign out_ctl_insert          = insert_issue;
   assign out_ctl_pop             = pop_issue;
   assign m_deq_valid             = deq_valid_q;
   assign m_deq_element           = deq_elem_q;
   assign out_global_overflow_bit = gov_q;
   assign out_pifo_count          = count_q;

endmodule

// File: tb/tb_pifo_calendar_enq_ctrl.sv
// tb/tb_pifo_calendar_enq_ctrl.sv - scoreboard bench for pifo_calendar_enq_ctrl

module tb_pifo_calendar_enq_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic        s_enq_valid;
   logic        s_enq_ready;
   logic [11:0] s_enq_address;
   logic [17:0] s_enq_delta;
   logic        s_deq_req;
   logic        m_deq_valid;
   logic [31:0] m_deq_element;
   logic [31:0] in_pifo_head;
   logic [31:0] out_pifo_input;
   logic        out_ctl_insert;
   logic        out_ctl_pop;
   logic        out_global_overflow_bit;
   logic [4:0]  out_pifo_count;

`ifdef PIFO_ENQ_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   int n_cmp  = 0;
   int n_fail = 0;
   logic [31:0] exp_ins [$];
   logic [31:0] exp_deq [$];

   always #5 clk = ~clk;

   pifo_calendar_enq_ctrl dut (
      .clk                     (clk),
      .rstn                    (rstn),
      .s_enq_valid             (s_enq_valid),
      .s_enq_ready             (s_enq_ready),
      .s_enq_address           (s_enq_address),
      .s_enq_delta             (s_enq_delta),
      .s_deq_req               (s_deq_req),
      .m_deq_valid             (m_deq_valid),
      .m_deq_element           (m_deq_element),
      .in_pifo_head            (in_pifo_head),
      .out_pifo_input          (out_pifo_input),
      .out_ctl_insert          (out_ctl_insert),
      .out_ctl_pop             (out_ctl_pop),
      .out_global_overflow_bit (out_global_overflow_bit),
      .out_pifo_count          (out_pifo_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every insert strobe and every dequeue pulse is matched against
   // the oldest expected element.
   always @(negedge clk) begin
      if (rstn === 1'b1) begin
         if (out_ctl_insert) begin
            if (exp_ins.size() == 0) chk("unexpected_insert", out_pifo_input, 32'h0);
            else chk("insert_element", out_pifo_input, exp_ins.pop_front());
         end else begin
            chk("idle_input", out_pifo_input, 32'h0);
         end
         if (m_deq_valid) begin
            if (exp_deq.size() == 0) chk("unexpected_deq", m_deq_element, 32'hFFFF_FFFF);
            else chk("deq_element", m_deq_element, exp_deq.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_enq(input logic [11:0] addr, input logic [17:0] delta);
      logic acc;
      acc = 1'b0;
      s_enq_valid   = 1'b1;
      s_enq_address = addr;
      s_enq_delta   = delta;
      for (int t = 0; t < 50 && !acc; t++) begin
         @(negedge clk);
         acc = s_enq_ready;
         tick();
      end
      if (!acc) chk("enq_timeout", 32'(acc), 32'h1);
      s_enq_valid = 1'b0;
   endtask

   task automatic do_pop(input logic [31:0] head);
      in_pifo_head = head;
      s_deq_req    = 1'b1;
      exp_deq.push_back(head);
      @(negedge clk);
      chk("pop_strobe", 32'(out_ctl_pop), 32'h1);
      tick();
      s_deq_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rstn = 1'b0; s_enq_valid = 1'b0; s_enq_address = '0; s_enq_delta = '0;
      s_deq_req = 1'b0; in_pifo_head = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 32'(out_pifo_count), 32'h0);
      chk("rst_ready", 32'(s_enq_ready), 32'h0);
      chk("rst_insert", 32'(out_ctl_insert), 32'h0);
      chk("rst_deq_valid", 32'(m_deq_valid), 32'h0);
      chk("rst_input", out_pifo_input, 32'h0);

      // First request right after reset release; insert latency N vs N+1.
      rstn = 1'b1;
      s_enq_valid = 1'b1; s_enq_address = 12'h00A; s_enq_delta = 18'd5;
      exp_ins.push_back(32'h8000_500A);
      @(negedge clk);
      chk("ready_first_cycle", 32'(s_enq_ready), 32'h1);
      chk("insert_cycle_n", 32'(out_ctl_insert), 32'(BYP));
      tick();
      s_enq_valid = 1'b0;
      @(negedge clk);
      chk("insert_cycle_n1", 32'(out_ctl_insert), 32'(!BYP));
      tick();
      chk("count_after_first", 32'(out_pifo_count), 32'h1);

      // Pop rank 0x3FFF0 so vtime sits just below the wrap point.
      do_pop(32'hBFFF_000A);
      chk("count_after_pop", 32'(out_pifo_count), 32'h0);
      chk("gov_after_pop0", 32'(out_global_overflow_bit), 32'h0);
      exp_ins.push_back(32'hC001_000B);
      do_enq(12'h00B, 18'h00020);
      repeat (3) tick();
      chk("count_after_wrap_enq", 32'(out_pifo_count), 32'h1);

      // Pop an overflow-epoch head; then a pop on an empty chain is ignored.
      do_pop(32'hC001_000B);
      chk("gov_after_pop1", 32'(out_global_overflow_bit), 32'h1);
      chk("count_empty", 32'(out_pifo_count), 32'h0);
      s_deq_req = 1'b1;
      @(negedge clk);
      chk("pop_on_empty", 32'(out_ctl_pop), 32'h0);
      tick();
      s_deq_req = 1'b0;
      chk("deq_valid_on_empty", 32'(m_deq_valid), 32'h0);

      // Fill the chain (vtime 0x10, epoch bit 1, no carry).
      for (int i = 0; i < 16; i++) begin
         exp_ins.push_back(32'hC000_0000 | ((32'h10 + i) << 12) | i);
         do_enq(12'(i), 18'(i));
      end
      repeat (3) tick();
      chk("count_full", 32'(out_pifo_count), 32'd16);

      // Four more requests only fill the staging FIFO.
      for (int i = 0; i < 4; i++) begin
         if (i == 0) exp_ins.push_back(32'hC011_0020);
         do_enq(12'(12'h020 + i), 18'(18'h100 + i));
      end
      @(negedge clk);
      chk("ready_fifo_full", 32'(s_enq_ready), 32'h0);
      chk("no_insert_chain_full", 32'(out_ctl_insert), 32'h0);
      tick();

      // Pop while full: insert and pop share the cycle, count holds.
      in_pifo_head = 32'hC001_0000;
      s_deq_req = 1'b1;
      exp_deq.push_back(32'hC001_0000);
      @(negedge clk);
      chk("same_cycle_pop", 32'(out_ctl_pop), 32'h1);
      chk("same_cycle_insert", 32'(out_ctl_insert), 32'h1);
      tick();
      s_deq_req = 1'b0;
      chk("count_holds_16", 32'(out_pifo_count), 32'd16);
      @(negedge clk);
      chk("ready_after_slot", 32'(s_enq_ready), 32'h1);

      // Reset with three requests still staged.
      #2;
      rstn = 1'b0;
      #1;
      chk("midrst_insert", 32'(out_ctl_insert), 32'h0);
      chk("midrst_pop", 32'(out_ctl_pop), 32'h0);
      chk("midrst_input", out_pifo_input, 32'h0);
      chk("midrst_deq_valid", 32'(m_deq_valid), 32'h0);
      chk("midrst_deq_elem", m_deq_element, 32'h0);
      chk("midrst_count", 32'(out_pifo_count), 32'h0);
      chk("midrst_ready", 32'(s_enq_ready), 32'h0);
      chk("midrst_gov", 32'(out_global_overflow_bit), 32'h0);
      tick();
      rstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("staged_discarded", 32'(out_ctl_insert), 32'h0);
      end
      tick();

      exp_ins.push_back(32'h8000_70FF);
      do_enq(12'h0FF, 18'd7);
      repeat (3) tick();
      chk("count_after_reset_enq", 32'(out_pifo_count), 32'h1);
      chk("inserts_outstanding", 32'(exp_ins.size()), 32'h0);
      chk("deqs_outstanding", 32'(exp_deq.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pifo_calendar_enq_ctrl.md
PIFO_CALENDAR_ENQ_CTRL -- requirements
Module: pifo_calendar_enq_ctrl

Interface
REQ-001 Parameter: ELEMENT_WIDTH, 32, PIFO element width {valid[31], overflow[30], rank[29:12], address[11:0]}.
REQ-002 Parameter: ELEMENT_RANK_WIDTH, 18, rank field width.
REQ-003 Parameter: PIFO_INFO_ADDRESS_WIDTH, 12, address field width.
REQ-004 Parameter: PIFO_DEPTH, 16, number of atoms in the downstream PIFO chain.
REQ-005 Parameter: FIFO_DEPTH, 4, enqueue staging FIFO entries (power of two, >=2).
REQ-006 Port: clk  in  1  sole clock; all state on rising edge.
REQ-007 Port: rstn  in  1  reset, asynchronous, active-low.
REQ-008 Port: s_enq_valid  in  1  enqueue request valid.
REQ-009 Port: s_enq_ready  out  1  enqueue accept; transfer when valid & ready.
REQ-010 Port: s_enq_address  in  12  packet buffer address.
REQ-011 Port: s_enq_delta  in  18  rank offset relative to current virtual time.
REQ-012 Port: s_deq_req  in  1  dequeue request, one pop per asserted cycle.
REQ-013 Port: m_deq_valid  out  1  one-cycle pulse, popped element valid.
REQ-014 Port: m_deq_element  out  32  popped element.
REQ-015 Port: in_pifo_head  in  32  head atom register output.
REQ-016 Port: out_pifo_input  out  32  element broadcast to all atoms.
REQ-017 Port: out_ctl_insert, out_ctl_pop  out  1 each  atom control strobes.
REQ-018 Port: out_global_overflow_bit  out  1  overflow bit of last dequeued element.
REQ-019 Port: out_pifo_count  out  $clog2(PIFO_DEPTH+1)  occupied atoms.

Function
REQ-020 Staging FIFO SHALL store {address, delta}; s_enq_ready = FIFO not full.
REQ-021 Insert SHALL issue in cycle N when FIFO non-empty and (count < PIFO_DEPTH or pop issues in N); otherwise FIFO head holds, never dropped.
REQ-022 Issued element SHALL be {1, ovf, rank, address}: {carry, rank} = vtime + delta (19-bit sum, rank = low 18 bits), ovf = global_overflow ^ carry, using register values of cycle N.
REQ-023 out_pifo_input SHALL be 0 (valid=0) in cycles with no insert.
REQ-024 Pop SHALL issue in cycle N when s_deq_req=1 and count>0; s_deq_req with count=0 ignored, no pulse.
REQ-025 On pop in N: at edge N+1, m_deq_element = in_pifo_head sampled in N, m_deq_valid=1 for one cycle, vtime = head rank, global_overflow = head overflow bit.
REQ-026 Simultaneous insert and pop SHALL assert both strobes in N; insert uses pre-update vtime/overflow; count unchanged.
REQ-027 count: +1 insert only, -1 pop only, never exceeds PIFO_DEPTH nor underflows.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; simultaneous push and pop on full FIFO is not permitted (ready=0), on empty FIFO governed by REQ-034.

Reset
REQ-029 rstn low SHALL clear immediately: FIFO pointers/contents, vtime, global_overflow, count, m_deq_valid, m_deq_element, out_ctl_insert, out_ctl_pop, out_pifo_input; s_enq_ready=0 while rstn low.
REQ-030 Reset mid-operation SHALL discard staged requests; the downstream atoms are reset by the same rstn.
REQ-031 First accept SHALL be possible in the first cycle after rstn deasserts.

Configuration
REQ-032 Macro PIFO_ENQ_BYPASS_EN controls the enqueue bypass path.
REQ-033 Without it: every request passes through the FIFO; minimum latency s_enq accept (N) to out_ctl_insert is N+1.
REQ-034 With it: when FIFO empty and insert allowed per REQ-021, the accepted request SHALL issue in the same cycle N and not be written to the FIFO; ordering with staged entries preserved.

Verification
REQ-035 Reset, enqueue delta=5 addr=0x00A -> out_pifo_input=0x8000500A (valid, ovf 0, rank 5), count 1.
REQ-036 Set vtime=0x3FFF0 via pop of rank 0x3FFF0 ovf 0; enqueue delta=0x20 -> rank 0x00010, overflow bit 1.
REQ-037 Fill PIFO to 16, offer 4 more -> s_enq_ready=0 after FIFO full, no insert strobe; one pop -> insert and pop same cycle, count stays 16.
REQ-038 s_deq_req with count 0 -> no out_ctl_pop, m_deq_valid stays 0; pop head ovf=1 -> out_global_overflow_bit=1 next cycle.
REQ-039 Assert rstn low mid-burst with 3 staged -> all outputs 0 same cycle, count 0, staged requests never inserted.
REQ-040 Build with and without PIFO_ENQ_BYPASS_EN: idle enqueue -> insert in cycle N vs N+1.
